// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - request/result bundle between the core controller and the multiplier
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_signed;
  logic             long_mul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  // Controller side: issues operands, consumes the product.
  modport master (
    output start, op_signed, long_mul, a, b,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  // Multiplier side.
  modport slave (
    input  start, op_signed, long_mul, a, b,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative radix-2 shift-add multiplier with sign fix-up and flags
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_sequencer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  // Low accumulator half starts out holding the multiplier and fills with
  // product bits from the top as the multiplier is shifted out the bottom.
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               neg_q,    neg_d;
  logic               long_q,   long_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               fn_q,     fn_d;
  logic               fz_q,     fz_d;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fin;

  // Magnitudes of the operands; -2^(W-1) maps onto the unsigned value 2^(W-1).
  always_comb begin
    a_abs = (bus.op_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    b_abs = (bus.op_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  // Datapath: conditional add of the multiplicand and the final sign correction.
  always_comb begin
    sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    prod     = {acc_hi_q, acc_lo_q};
    prod_fin = neg_q ? (~prod + 1'b1) : prod;
  end

  // Control FSM and next-state for all registers.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    neg_d    = neg_q;
    long_d   = long_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    fn_d     = fn_q;
    fz_d     = fz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = a_abs;
          acc_lo_d = b_abs;
          acc_hi_d = '0;
          count_d  = '0;
          neg_d    = bus.op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          long_d   = bus.long_mul;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        // Results are loaded here so they are already visible while done is high.
        res_lo_d = prod_fin[WIDTH-1:0];
        res_hi_d = long_q ? prod_fin[2*WIDTH-1:WIDTH] : '0;
        fn_d     = long_q ? prod_fin[2*WIDTH-1] : prod_fin[WIDTH-1];
        fz_d     = long_q ? ~|prod_fin : ~|prod_fin[WIDTH-1:0];
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; an asynchronous reset aborts any operation and clears results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      long_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      long_q   <= long_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      fn_q     <= fn_d;
      fz_q     <= fz_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flag_n    = fn_q;
  assign bus.flag_z    = fz_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed vector bench for mul_sequencer
module tb_mul_sequencer;

  logic clk;
  logic reset;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        l;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
  } vec_t;

  vec_t vecs [12];

  int errors = 0;
  int checks = 0;

  int          lat1, lat2, done_n, busy_n;
  logic [31:0] lo1, hi1, lo2;
  logic        n1, z1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one op in cycle 0 and watches 75 cycles; start is re-pulsed with
  // (ia, ib) in cycles inj1/inj2 (0 = never) to probe accept behaviour.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic l,
                       input int inj1, input int inj2, input logic [31:0] ia, input logic [31:0] ib);
    lat1 = 0; lat2 = 0; done_n = 0; busy_n = 0;
    lo1 = '0; hi1 = '0; n1 = 1'b0; z1 = 1'b0; lo2 = '0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.op_signed = s; bus.long_mul = l; bus.start = 1'b1;
    chk("busy_cycle0", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D; bus.op_signed = ~s; bus.long_mul = ~l;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat1 == 0) begin
          lat1 = cyc;
          lo1 = bus.result_lo; hi1 = bus.result_hi; n1 = bus.flag_n; z1 = bus.flag_z;
        end else if (lat2 == 0) begin
          lat2 = cyc;
          lo2 = bus.result_lo;
        end
      end
      if (cyc == inj1 || cyc == inj2) begin
        bus.a = ia; bus.b = ib; bus.op_signed = 1'b0; bus.long_mul = 1'b0; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'd3,        32'd5,        1'b0, 1'b0, 32'h0000000F, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd6,        1'b1, 1'b1, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h00000000, 32'h40000000, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[4]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[5]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b1, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFFFFF9, 32'd6,        1'b1, 1'b0, 32'hFFFFFFD6, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{32'h80000000, 32'd1,        1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[10] = '{32'd0,        32'hFFFFFFFB, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1, 32'hFFFE0001, 32'h00000000, 1'b0, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.op_signed = 1'b0; bus.long_mul = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_lo",   64'(bus.result_lo), 64'd0);
    chk("rst_hi",   64'(bus.result_hi), 64'd0);
    chk("rst_n",    64'(bus.flag_n), 64'd0);
    chk("rst_z",    64'(bus.flag_z), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].l, 0, 0, '0, '0);
      chk($sformatf("v%0d_latency", i), 64'(lat1), 64'd34);
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'd34);
      chk($sformatf("v%0d_done_count", i), 64'(done_n), 64'd1);
      chk($sformatf("v%0d_lo", i), 64'(lo1), 64'(vecs[i].lo));
      chk($sformatf("v%0d_hi", i), 64'(hi1), 64'(vecs[i].hi));
      chk($sformatf("v%0d_n", i), 64'(n1), 64'(vecs[i].n));
      chk($sformatf("v%0d_z", i), 64'(z1), 64'(vecs[i].z));
      chk($sformatf("v%0d_hold_lo", i), 64'(bus.result_lo), 64'(vecs[i].lo));
    end

    // Start in cycle 10 is dropped; start in cycle 35 is the earliest accept.
    do_op(32'd3, 32'd5, 1'b0, 1'b0, 10, 35, 32'd2, 32'd2);
    chk("bb_first_latency", 64'(lat1), 64'd34);
    chk("bb_first_lo", 64'(lo1), 64'd15);
    chk("bb_second_latency", 64'(lat2), 64'd69);
    chk("bb_second_lo", 64'(lo2), 64'd4);
    chk("bb_done_count", 64'(done_n), 64'd2);
    chk("bb_busy_cycles", 64'(busy_n), 64'd68);

    // Asynchronous reset in cycle 20 of an in-flight op.
    @(negedge clk);
    bus.a = 32'd3; bus.b = 32'd5; bus.op_signed = 1'b0; bus.long_mul = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_lo",   64'(bus.result_lo), 64'd0);
    chk("mid_rst_hi",   64'(bus.result_hi), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(32'd4, 32'd4, 1'b0, 1'b0, 0, 0, '0, '0);
    chk("post_rst_latency", 64'(lat1), 64'd34);
    chk("post_rst_lo", 64'(lo1), 64'd16);
    chk("post_rst_done_count", 64'(done_n), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
